// File: rtl/config_mux_pipe_if.sv
// Bus bundle for config_mux_pipe: serial config chain plus data beat.
// The data side carries one beat per cycle with a valid tag and no backpressure.
interface config_mux_pipe_if #(
    parameter int N_INPUTS = 20
);
    logic                config_enable;
    logic                config_in;
    logic                config_out;
    logic                config_load;
    logic                valid_in;
    logic [N_INPUTS-1:0] data_in;
    logic                valid_out;
    logic                data_out;

    modport master (
        output config_enable,
        output config_in,
        output config_load,
        output valid_in,
        output data_in,
        input  config_out,
        input  valid_out,
        input  data_out
    );

    modport slave (
        input  config_enable,
        input  config_in,
        input  config_load,
        input  valid_in,
        input  data_in,
        output config_out,
        output valid_out,
        output data_out
    );
endinterface

// File: rtl/config_mux_pipe.sv
// N:1 routing mux: serially configured selector, 2:1 tree, optional per-level pipe regs.
// Define CONFIG_SHADOW_EN to shift into a shadow register applied by config_load.
module config_mux_pipe #(
    parameter int                   N_INPUTS  = 20,
    parameter int                   SEL_WIDTH = 5,
    parameter logic [SEL_WIDTH-1:0] PIPE_MASK = '0
) (
    input logic              clock,
    input logic              nreset,
    config_mux_pipe_if.slave bus
);
    localparam int W = 1 << SEL_WIDTH;

    logic [SEL_WIDTH-1:0] chain_q;
    logic [SEL_WIDTH:0]   chain_sh;
    logic [SEL_WIDTH-1:0] sel_act;
    logic                 gate;

    assign chain_sh = {bus.config_in, chain_q};

`ifdef CONFIG_SHADOW_EN
    logic [SEL_WIDTH-1:0] act_q;

    // Load samples the pre-shift shadow when both strobes coincide.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            chain_q <= '0;
            act_q   <= '0;
        end else begin
            if (bus.config_enable)
                chain_q <= chain_sh[SEL_WIDTH:1];
            if (bus.config_load)
                act_q <= chain_q;
        end
    end

    assign sel_act = act_q;
    assign gate    = bus.config_load;
`else
    logic unused_load;

    always_ff @(posedge clock) begin
        if (!nreset)
            chain_q <= '0;
        else if (bus.config_enable)
            chain_q <= chain_sh[SEL_WIDTH:1];
    end

    assign sel_act     = chain_q;
    assign gate        = bus.config_enable;
    assign unused_load = bus.config_load;
`endif

    assign bus.config_out = chain_q[0];

    logic [SEL_WIDTH:0][W-1:0]         lvl_d;
    logic [SEL_WIDTH:0]                lvl_v;
    logic [SEL_WIDTH:0][SEL_WIDTH-1:0] lvl_s;
    logic                              entry_off;

    // Reset also blanks entry so combinational levels output 0 in reset.
    assign entry_off = gate | ~nreset;

    assign lvl_d[SEL_WIDTH] = entry_off ? '0 : W'(bus.data_in);
    assign lvl_v[SEL_WIDTH] = bus.valid_in & ~entry_off;
    assign lvl_s[SEL_WIDTH] = sel_act;

    for (genvar k = 0; k < SEL_WIDTH; k++) begin : g_lvl
        localparam int H = 1 << k;
        logic [W-1:0] m;

        always_comb begin
            m = '0;
            if (lvl_s[k+1][k])
                m[H-1:0] = lvl_d[k+1][2*H-1:H];
            else
                m[H-1:0] = lvl_d[k+1][H-1:0];
        end

        if (PIPE_MASK[k]) begin : g_reg
            logic [W-1:0]         d_q;
            logic                 v_q;
            logic [SEL_WIDTH-1:0] s_q;

            always_ff @(posedge clock) begin
                if (!nreset) begin
                    d_q <= '0;
                    v_q <= 1'b0;
                    s_q <= '0;
                end else begin
                    d_q <= m;
                    v_q <= lvl_v[k+1];
                    s_q <= lvl_s[k+1];
                end
            end

            assign lvl_d[k] = d_q;
            assign lvl_v[k] = v_q;
            assign lvl_s[k] = s_q;
        end else begin : g_comb
            assign lvl_d[k] = m;
            assign lvl_v[k] = lvl_v[k+1];
            assign lvl_s[k] = lvl_s[k+1];
        end
    end

    assign bus.data_out  = lvl_d[0][0];
    assign bus.valid_out = lvl_v[0];

    logic unused_bits;
    assign unused_bits = ^{lvl_d, lvl_s, chain_sh[0]};
endmodule
